// File: rtl/core_pkg.sv
// Shared register-file write request types for the core writeback path and the UART loader.
package core_pkg;

    localparam int unsigned REG_ADDR_W = 5;
    localparam int unsigned DATA_W     = 32;

    typedef struct packed {
        logic [REG_ADDR_W-1:0] rd;
        logic [DATA_W-1:0]     data;
    } wreq_t;

    typedef enum logic [1:0] {
        GNT_NONE = 2'd0,
        GNT_CORE = 2'd1,
        GNT_UART = 2'd2
    } gnt_src_e;

endpackage

// File: rtl/wport_fifo.sv
// Synchronous in-order FIFO of UART write requests; exposes per-entry valid/rd for hazard lookup.
module wport_fifo
    import core_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic                  i_push,
    input  wreq_t                 i_push_req,
    input  logic                  i_pop,
    output wreq_t                 o_head,
    output logic                  o_full,
    output logic                  o_empty,
    output logic [DEPTH-1:0]      o_entry_vld,
    output logic [REG_ADDR_W-1:0] o_entry_rd [DEPTH]
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    wreq_t              r_mem [DEPTH];
    logic [PTR_W-1:0]   r_wptr;
    logic [PTR_W-1:0]   r_rptr;
    logic [CNT_W-1:0]   r_count;
    logic [DEPTH-1:0]   r_vld;

    logic               w_push;
    logic               w_pop;
    logic [DEPTH-1:0]   w_vld_nxt;

    assign o_full  = (r_count == CNT_W'(DEPTH));
    assign o_empty = (r_count == '0);
    assign w_push  = i_push && !o_full;
    assign w_pop   = i_pop && !o_empty;
    assign o_head  = r_mem[r_rptr];

    // A push never lands on the head slot being popped: push requires !full, pop requires !empty.
    always_comb begin
        w_vld_nxt = r_vld;
        if (w_pop)  w_vld_nxt[r_rptr] = 1'b0;
        if (w_push) w_vld_nxt[r_wptr] = 1'b1;
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
            r_vld   <= '0;
        end else begin
            r_vld <= w_vld_nxt;
            if (w_push) begin
                r_mem[r_wptr] <= i_push_req;
                r_wptr        <= r_wptr + 1'b1;
            end
            if (w_pop) r_rptr <= r_rptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_comb begin
        o_entry_vld = r_vld;
        for (int unsigned i = 0; i < DEPTH; i++) o_entry_rd[i] = r_mem[i].rd;
    end

endmodule

// File: rtl/regfile_wport_arbiter.sv
// Arbitrates the register-file write port between core writeback and queued UART writes,
// with a starvation bound for UART and read-after-write hazard reporting to decode.
module regfile_wport_arbiter
    import core_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH   = 4,
    parameter int unsigned STARVE_LIMIT = 8
) (
    input  logic                  CLK,
    input  logic                  reset,
    input  logic                  wb_valid,
    input  logic [REG_ADDR_W-1:0] wb_rd,
    input  logic [DATA_W-1:0]     wb_data,
    output logic                  wb_ready,
    input  logic                  uart_valid,
    input  logic [REG_ADDR_W-1:0] uart_rd,
    input  logic [DATA_W-1:0]     uart_data,
    output logic                  uart_ready,
    input  logic [REG_ADDR_W-1:0] rs,
    input  logic [REG_ADDR_W-1:0] rt,
    output logic                  hazard_rs,
    output logic                  hazard_rt,
    output logic                  rf_we,
    output logic [REG_ADDR_W-1:0] rf_rw,
    output logic [DATA_W-1:0]     rf_wdata
);

    localparam int unsigned ST_W = $clog2(STARVE_LIMIT + 1);

    logic [ST_W-1:0]       r_starve;

    wreq_t                 w_head;
    wreq_t                 w_push_req;
    wreq_t                 w_sel;
    logic                  w_full;
    logic                  w_empty;
    logic                  w_push;
    logic                  w_force;
    logic                  w_core_gnt;
    logic                  w_uart_gnt;
    gnt_src_e              w_src;
    logic [FIFO_DEPTH-1:0] w_entry_vld;
    logic [REG_ADDR_W-1:0] w_entry_rd [FIFO_DEPTH];
    logic                  w_rs_hit;
    logic                  w_rt_hit;

    assign w_push_req = '{rd: uart_rd, data: uart_data};
    assign uart_ready = !reset && !w_full;
    assign w_push     = uart_valid && uart_ready;

    wport_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .i_clk       (CLK),
        .i_reset     (reset),
        .i_push      (w_push),
        .i_push_req  (w_push_req),
        .i_pop       (w_uart_gnt),
        .o_head      (w_head),
        .o_full      (w_full),
        .o_empty     (w_empty),
        .o_entry_vld (w_entry_vld),
        .o_entry_rd  (w_entry_rd)
    );

    always_comb begin
        w_force    = !reset && !w_empty && (r_starve >= ST_W'(STARVE_LIMIT));
        wb_ready   = !reset && !w_force;
        w_core_gnt = wb_ready && wb_valid;
        w_uart_gnt = !reset && !w_empty && (w_force || !wb_valid);
        w_src      = GNT_NONE;
        w_sel      = w_head;
        if (w_core_gnt) begin
            w_src = GNT_CORE;
            w_sel = '{rd: wb_rd, data: wb_data};
        end else if (w_uart_gnt) begin
            w_src = GNT_UART;
        end
    end

    // Counter only runs while UART work is waiting; any UART slot or an empty FIFO restarts it.
    always_ff @(posedge CLK) begin
        if (reset) begin
            r_starve <= '0;
        end else if (w_uart_gnt || w_empty) begin
            r_starve <= '0;
        end else if (w_core_gnt && (r_starve < ST_W'(STARVE_LIMIT))) begin
            r_starve <= r_starve + 1'b1;
        end
    end

    // Writes to register 0 still consume the slot but never assert the enable.
    always_ff @(posedge CLK) begin
        if (reset) begin
            rf_we    <= 1'b0;
            rf_rw    <= '0;
            rf_wdata <= '0;
        end else if (w_src == GNT_NONE) begin
            rf_we    <= 1'b0;
        end else begin
            rf_we    <= (w_sel.rd != '0);
            rf_rw    <= w_sel.rd;
            rf_wdata <= w_sel.data;
        end
    end

    always_comb begin
        w_rs_hit = rf_we && (rf_rw == rs);
        w_rt_hit = rf_we && (rf_rw == rt);
        for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
            if (w_entry_vld[i] && (w_entry_rd[i] == rs)) w_rs_hit = 1'b1;
            if (w_entry_vld[i] && (w_entry_rd[i] == rt)) w_rt_hit = 1'b1;
        end
        hazard_rs = !reset && (rs != '0) && w_rs_hit;
        hazard_rt = !reset && (rt != '0) && w_rt_hit;
    end

endmodule

// File: tb/tb_regfile_wport_arbiter.sv
// Randomized plus directed bench for regfile_wport_arbiter against a queue-based reference model.
module tb_regfile_wport_arbiter;
    import core_pkg::*;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned LIMIT = 8;

    logic        CLK = 1'b0;
    logic        reset;
    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        wb_ready;
    logic        uart_valid;
    logic [4:0]  uart_rd;
    logic [31:0] uart_data;
    logic        uart_ready;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic        hazard_rs;
    logic        hazard_rt;
    logic        rf_we;
    logic [4:0]  rf_rw;
    logic [31:0] rf_wdata;

    always #5 CLK = ~CLK;

    regfile_wport_arbiter #(
        .FIFO_DEPTH   (DEPTH),
        .STARVE_LIMIT (LIMIT)
    ) dut (
        .CLK        (CLK),
        .reset      (reset),
        .wb_valid   (wb_valid),
        .wb_rd      (wb_rd),
        .wb_data    (wb_data),
        .wb_ready   (wb_ready),
        .uart_valid (uart_valid),
        .uart_rd    (uart_rd),
        .uart_data  (uart_data),
        .uart_ready (uart_ready),
        .rs         (rs),
        .rt         (rt),
        .hazard_rs  (hazard_rs),
        .hazard_rt  (hazard_rt),
        .rf_we      (rf_we),
        .rf_rw      (rf_rw),
        .rf_wdata   (rf_wdata)
    );

    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;

    // Reference model: pending UART writes as a queue, waiting-cycle count, last port write.
    wreq_t       m_q [$];
    int unsigned m_starve;
    logic        m_we;
    logic [4:0]  m_rw;
    logic [31:0] m_wdata;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic pending_hit(input logic [4:0] r);
        logic hit;
        hit = m_we && (m_rw == r);
        foreach (m_q[k]) if (m_q[k].rd == r) hit = 1'b1;
        return (r != 5'd0) && hit;
    endfunction

    task automatic step(input logic rst, input logic wv, input logic [4:0] wrd, input logic [31:0] wd,
                        input logic uv, input logic [4:0] urd, input logic [31:0] ud,
                        input logic [4:0] rsv, input logic [4:0] rtv);
        int unsigned sz;
        logic        force_u, exp_wbr, exp_ur, core_g, uart_g;
        wreq_t       hd;
        @(negedge CLK);
        reset = rst; wb_valid = wv; wb_rd = wrd; wb_data = wd;
        uart_valid = uv; uart_rd = urd; uart_data = ud; rs = rsv; rt = rtv;
        #1;
        sz      = m_q.size();
        force_u = !rst && (m_starve >= LIMIT) && (sz > 0);
        exp_wbr = !rst && !force_u;
        exp_ur  = !rst && (sz < DEPTH);
        check("wb_ready",   32'(wb_ready),   32'(exp_wbr));
        check("uart_ready", 32'(uart_ready), 32'(exp_ur));
        check("rf_we",      32'(rf_we),      32'(m_we));
        check("rf_rw",      32'(rf_rw),      32'(m_rw));
        check("rf_wdata",   rf_wdata,        m_wdata);
        check("hazard_rs",  32'(hazard_rs),  32'(!rst && pending_hit(rsv)));
        check("hazard_rt",  32'(hazard_rt),  32'(!rst && pending_hit(rtv)));
        if (rst) begin
            m_q.delete();
            m_starve = 0; m_we = 1'b0; m_rw = '0; m_wdata = '0;
        end else begin
            core_g = exp_wbr && wv;
            uart_g = (sz > 0) && (force_u || !wv);
            if (core_g) begin
                m_we = (wrd != 5'd0); m_rw = wrd; m_wdata = wd;
            end else if (uart_g) begin
                hd = m_q.pop_front();
                m_we = (hd.rd != 5'd0); m_rw = hd.rd; m_wdata = hd.data;
            end else begin
                m_we = 1'b0;
            end
            if (uart_g || sz == 0)                 m_starve = 0;
            else if (core_g && m_starve < LIMIT)   m_starve++;
            if (uv && exp_ur) m_q.push_back('{rd: urd, data: ud});
        end
    endtask

    task automatic idle(input int unsigned n, input logic wv, input logic [4:0] rsv);
        for (int unsigned k = 0; k < n; k++)
            step(1'b0, wv, 5'd4, 32'h1000 + k, 1'b0, 5'd0, 32'd0, rsv, 5'd0);
    endtask

    initial begin
        int unsigned wprob;
        reset = 1'b1; wb_valid = 1'b0; wb_rd = '0; wb_data = '0;
        uart_valid = 1'b0; uart_rd = '0; uart_data = '0; rs = '0; rt = '0;
        @(posedge CLK);
        m_q.delete(); m_starve = 0; m_we = 1'b0; m_rw = '0; m_wdata = '0;

        // Reset held with requests pending, then release.
        step(1'b1, 1'b1, 5'd5, 32'hAAAA, 1'b1, 5'd6, 32'hBBBB, 5'd6, 5'd5);
        step(1'b1, 1'b1, 5'd5, 32'hAAAA, 1'b1, 5'd6, 32'hBBBB, 5'd6, 5'd5);
        idle(1, 1'b0, 5'd0);
        // Core only.
        step(1'b0, 1'b1, 5'd3, 32'hDEADBEEF, 1'b0, 5'd0, 32'd0, 5'd3, 5'd0);
        idle(2, 1'b0, 5'd3);
        // UART only, hazard window on rs=7.
        step(1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd7, 32'h12, 5'd7, 5'd7);
        idle(4, 1'b0, 5'd7);
        // Starvation: one queued entry under continuous core load.
        step(1'b0, 1'b1, 5'd2, 32'h55, 1'b1, 5'd9, 32'h99, 5'd9, 5'd2);
        idle(12, 1'b1, 5'd9);
        // Full FIFO: five pushes with the core busy, then drain.
        for (int unsigned k = 0; k < 5; k++)
            step(1'b0, 1'b1, 5'd1, 32'h200 + k, 1'b1, 5'(10 + k), 32'h300 + k, 5'd12, 5'd14);
        idle(8, 1'b0, 5'd11);
        // Register 0 write.
        step(1'b0, 1'b1, 5'd0, 32'hFFFF, 1'b0, 5'd0, 32'd0, 5'd0, 5'd0);
        idle(2, 1'b0, 5'd0);
        // Reset with three queued entries.
        for (int unsigned k = 0; k < 3; k++)
            step(1'b0, 1'b1, 5'd8, 32'h400 + k, 1'b1, 5'(20 + k), 32'h500 + k, 5'd20, 5'd21);
        step(1'b1, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 5'd20, 5'd21);
        step(1'b1, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 5'd20, 5'd21);
        idle(4, 1'b0, 5'd20);

        for (int unsigned i = 0; i < 3000; i++) begin
            case ((i / 500) % 4)
                0:       wprob = 90;
                1:       wprob = 50;
                2:       wprob = 10;
                default: wprob = 100;
            endcase
            step($urandom_range(0, 199) == 0,
                 $urandom_range(0, 99) < wprob, 5'($urandom_range(0, 7)), $urandom(),
                 $urandom_range(0, 1) == 1, 5'($urandom_range(0, 7)), $urandom(),
                 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/regfile_wport_arbiter.md
# regfile_wport_arbiter

Shares the single register-file write port between the core writeback stage and the UART program/data loader. Core writebacks win by default. UART writes are buffered in a small FIFO, and a starvation counter guarantees they drain. The block drives a registered write port into the register file and reports read-after-write hazards on queued UART writes to the decode stage.

## Interface
- `FIFO_DEPTH`, 4: UART write-request FIFO entries, a power of two ≥2.
- `STARVE_LIMIT`, 8: consecutive core grants allowed while the UART FIFO is non-empty, ≥1.
- `CLK` input 1: clock, rising edge.
- `reset` input 1: reset, synchronous, active-high.
- `wb_valid` input 1: core writeback request.
- `wb_rd` input 5: core destination register.
- `wb_data` input 32: core write data.
- `wb_ready` output 1: core request accepted this cycle; the core stalls when this is low.
- `uart_valid` input 1: UART write request.
- `uart_rd` input 5: UART destination register.
- `uart_data` input 32: UART write data.
- `uart_ready` output 1: FIFO can accept a request.
- `rs`, `rt` input 5 each: decode-stage source registers.
- `hazard_rs`, `hazard_rt` output 1 each: a pending UART write targets `rs`/`rt`.
- `rf_we` output 1: register-file write enable, registered.
- `rf_rw` output 5: register-file write address, registered.
- `rf_wdata` output 32: register-file write data, registered.

## Operation
- **UART push**: on `uart_valid && uart_ready`. `uart_ready = !full`, decoded from the registered count only. There is no pass-through, so a push while full is refused even when a pop happens in the same cycle.
- **Arbitration**, once per cycle:
  - `force_uart = (starve_cnt >= STARVE_LIMIT) && !empty`.
  - When `force_uart` is set: pop the FIFO head and drive `wb_ready = 0`.
  - Otherwise: `wb_ready = 1`. If `wb_valid`, the core is granted. Else, if the FIFO is non-empty, the FIFO head is popped.
- **starve_cnt**:
  - Increments when the core is granted and the FIFO is non-empty.
  - Clears on any UART grant or whenever the FIFO is empty.
  - Saturates at `STARVE_LIMIT`.
- **Grant register**: the granted request loads `rf_we`/`rf_rw`/`rf_wdata` on the next edge. With no grant, `rf_we = 0` and `rf_rw`/`rf_wdata` hold their values.
- **Register 0**: a request to register 0 is accepted and consumes its slot, but `rf_we` stays 0 for that slot.
- **Hazards**:
  - `hazard_rs = (rs != 0) && (any valid FIFO entry has rd == rs, or (rf_we && rf_rw == rs))`. `hazard_rt` is the same with `rt`.
  - Both are combinational.
  - Core writebacks are not tracked; forwarding handles them.
- **Reset**: FIFO empty, `starve_cnt = 0`, `rf_we = 0`, `rf_rw = 0`, `rf_wdata = 0`. While `reset` is high, `wb_ready = 0`, `uart_ready = 0` and hazards are 0. Reset mid-operation discards all queued UART writes.

## Timing
- **Core**: accepted in cycle N, `rf_we` high in N+1, data visible in the register file from N+2.
- **UART**: pushed in cycle N, earliest grant in N+1, `rf_we` in N+2.
- **Throughput**: at most one write per cycle. Under a continuous core load, UART gets at least one slot every `STARVE_LIMIT+1` cycles.
- **Simultaneous push and pop**: count is unchanged and the order is preserved, FIFO strictly in order.
- **Pointers**: wrap modulo `FIFO_DEPTH`. The count is `$clog2(FIFO_DEPTH)+1` bits wide.

## Structure
- **Package `core_pkg`**:
  - `REG_ADDR_W = 5` and `DATA_W = 32`.
  - Packed struct `wreq_t {rd, data}`, shared with the loader.
- **Sub-module `wport_fifo`**:
  - Synchronous FIFO of `wreq_t`, parameterised by depth.
  - Exposes `full`/`empty`, the head entry, and per-entry valid and rd for the hazard compare.
- **Top level**: arbitration, the starve counter, the grant register and the hazard compare.

## Test plan
- **Reset**: hold `reset` 2 cycles with requests pending -> all outputs 0, `uart_ready = 0`. After release, `uart_ready = 1` and the FIFO is empty.
- **Core only**: `wb_rd = 3`, `wb_data = 0xDEADBEEF` in cycle N -> `wb_ready = 1` in N. In N+1: `rf_we = 1`, `rf_rw = 3`, `rf_wdata = 0xDEADBEEF`.
- **UART only**: push `rd = 7`, `data = 0x12` in N -> `hazard_rs = 1` with `rs = 7` from N+1 through N+2. In N+2: `rf_we = 1`, `rf_rw = 7`. `hazard_rs = 0` in N+3.
- **Starvation**: `STARVE_LIMIT = 8`, core valid every cycle, one UART entry queued -> core granted 8 cycles. Cycle 9: `wb_ready = 0` and the UART entry is written. The core resumes in cycle 10.
- **Full FIFO**:
  - Core busy, 5 UART pushes -> 4 accepted, `uart_ready = 0` on the 5th.
  - Drained -> writes appear in push order.
- **Register 0 and mid-operation reset**:
  - Core write to `rd = 0` -> `wb_ready = 1`, `rf_we` stays 0.
  - `reset` with 3 queued entries -> no further `rf_we` pulses; the FIFO is empty after release.
